// File: rtl/latsnq_ctrl_pkg.sv
// Shared types and helpers for the latsnq bank writer: FSM state encoding and
// phase counter sizing.
package latsnq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_PULSE  = 3'd2,
      ST_PRESET = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

   // Width needed to hold the longest phase length as a down-count start value.
   function automatic int cnt_width(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
      int m;
      m = setup_cyc;
      if (pulse_cyc > m) m = pulse_cyc;
      if (hold_cyc > m) m = hold_cyc;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/latsnq_phase_cnt.sv
// Loadable phase down-counter with zero flag; load takes effect at the next edge.
// Counts down to zero and parks there; no backpressure, the FSM owns sequencing.
module latsnq_phase_cnt #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          zero
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/latsnq_bank_writer.sv
// Sequences D/E/SETN for a latsnq latch bank: setup, pulse and hold phases per request.
// Write occupies SETUP+PULSE+HOLD cycles, preset PULSE+HOLD; IN_READY only while idle.
module latsnq_bank_writer
   import latsnq_ctrl_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             WR_VALID,
   input  logic [WIDTH-1:0] WR_DATA,
   input  logic             PRE_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] D,
   output logic             E,
   output logic             SETN,
   output logic             DONE,
   output logic [WIDTH-1:0] MIRROR
);

   localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

   state_t        state;
   logic          cnt_zero;
   logic          cnt_load;
   logic [CW-1:0] cnt_val;
   logic          pre_acc;
   logic          wr_acc;

   assign IN_READY = (state == ST_IDLE);
   // Preset has priority; a simultaneous write stays pending on its own valid.
   assign pre_acc  = IN_READY && PRE_VALID;
   assign wr_acc   = IN_READY && WR_VALID && !PRE_VALID;

   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = '0;
      case (state)
         ST_IDLE: begin
            if (pre_acc) begin
               cnt_load = 1'b1;
               cnt_val  = PULSE_LD;
            end else if (wr_acc) begin
               cnt_load = 1'b1;
               cnt_val  = SETUP_LD;
            end
         end
         ST_SETUP: begin
            cnt_load = cnt_zero;
            cnt_val  = PULSE_LD;
         end
         ST_PULSE, ST_PRESET: begin
            cnt_load = cnt_zero;
            cnt_val  = HOLD_LD;
         end
         default: begin
            cnt_load = 1'b0;
            cnt_val  = '0;
         end
      endcase
   end

   latsnq_phase_cnt #(
      .CW(CW)
   ) u_phase_cnt (
      .clk      (CLK),
      .rst      (RST),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= ST_IDLE;
         D      <= '0;
         E      <= 1'b0;
         SETN   <= 1'b1;
         DONE   <= 1'b0;
         MIRROR <= '0;
      end else begin
         DONE <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pre_acc) begin
                  SETN  <= 1'b0;
                  state <= ST_PRESET;
               end else if (wr_acc) begin
                  D     <= WR_DATA;
                  state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt_zero) begin
                  E     <= 1'b1;
                  state <= ST_PULSE;
               end
            end
            ST_PULSE: begin
               if (cnt_zero) begin
                  E      <= 1'b0;
                  MIRROR <= D;
                  state  <= ST_HOLD;
               end
            end
            ST_PRESET: begin
               if (cnt_zero) begin
                  SETN   <= 1'b1;
                  MIRROR <= '1;
                  state  <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (cnt_zero) begin
                  DONE  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: begin
               E     <= 1'b0;
               SETN  <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latsnq_bank_writer.sv
// Directed bench for latsnq_bank_writer: default-parameter instance driven from a
// cycle table plus hand sequences, and a SETUP=3/PULSE=1/HOLD=4 instance.
module tb_latsnq_bank_writer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Default-parameter instance
   logic       rst_a, wr_vld_a, pre_vld_a;
   logic [7:0] wr_dat_a;
   logic       rdy_a, e_a, setn_a, done_a;
   logic [7:0] d_a, mir_a;

   latsnq_bank_writer #(
      .WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
   ) dut_a (
      .CLK(clk), .RST(rst_a), .WR_VALID(wr_vld_a), .WR_DATA(wr_dat_a),
      .PRE_VALID(pre_vld_a), .IN_READY(rdy_a), .D(d_a), .E(e_a),
      .SETN(setn_a), .DONE(done_a), .MIRROR(mir_a)
   );

   // Long-setup / short-pulse / long-hold instance
   logic       rst_b, wr_vld_b, pre_vld_b;
   logic [7:0] wr_dat_b;
   logic       rdy_b, e_b, setn_b, done_b;
   logic [7:0] d_b, mir_b;

   latsnq_bank_writer #(
      .WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)
   ) dut_b (
      .CLK(clk), .RST(rst_b), .WR_VALID(wr_vld_b), .WR_DATA(wr_dat_b),
      .PRE_VALID(pre_vld_b), .IN_READY(rdy_b), .D(d_b), .E(e_b),
      .SETN(setn_b), .DONE(done_b), .MIRROR(mir_b)
   );

   typedef struct {
      logic       rst;
      logic       wr;
      logic       pre;
      logic [7:0] dat;
      logic       rdy;
      logic [7:0] d;
      logic       e;
      logic       setn;
      logic       done;
      logic [7:0] mir;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic rst, input logic wr, input logic pre,
                               input logic [7:0] dat, input logic rdy, input logic [7:0] d,
                               input logic e, input logic setn, input logic done,
                               input logic [7:0] mir);
      vec_t v;
      v.rst = rst; v.wr = wr; v.pre = pre; v.dat = dat;
      v.rdy = rdy; v.d = d; v.e = e; v.setn = setn; v.done = done; v.mir = mir;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   initial begin
      int         acc_cyc [2];
      int         n_acc;
      int         viol;
      int         n_done;
      int         e_cycles;
      int         rise_k;
      int         done_k;
      int         e_cnt;
      int         done_cnt;
      int         setn_lo;
      logic [7:0] last_dat;
      logic       acc;

      // inputs before edge k          -> outputs after edge k
      //            rst wr pre dat     rdy d     e  sn dn mir
      vecs[0]  = mk(1, 0, 0, 8'h00,  1, 8'h00, 0, 1, 0, 8'h00);
      vecs[1]  = mk(0, 0, 0, 8'h00,  1, 8'h00, 0, 1, 0, 8'h00);
      vecs[2]  = mk(0, 1, 0, 8'hA5,  0, 8'hA5, 0, 1, 0, 8'h00); // write accepted
      vecs[3]  = mk(0, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 0, 8'h00);
      vecs[4]  = mk(0, 0, 0, 8'h00,  0, 8'hA5, 1, 1, 0, 8'h00);
      vecs[5]  = mk(0, 0, 0, 8'h00,  0, 8'hA5, 0, 1, 0, 8'hA5); // hold
      vecs[6]  = mk(0, 0, 0, 8'h00,  1, 8'hA5, 0, 1, 1, 8'hA5);
      vecs[7]  = mk(0, 0, 0, 8'h00,  1, 8'hA5, 0, 1, 0, 8'hA5);
      vecs[8]  = mk(0, 1, 1, 8'h3C,  0, 8'hA5, 0, 0, 0, 8'hA5); // preset wins
      vecs[9]  = mk(0, 1, 0, 8'h3C,  0, 8'hA5, 0, 0, 0, 8'hA5);
      vecs[10] = mk(0, 1, 0, 8'h3C,  0, 8'hA5, 0, 1, 0, 8'hFF);
      vecs[11] = mk(0, 1, 0, 8'h3C,  1, 8'hA5, 0, 1, 1, 8'hFF);
      vecs[12] = mk(0, 1, 0, 8'h3C,  0, 8'h3C, 0, 1, 0, 8'hFF); // pending write taken
      vecs[13] = mk(0, 0, 0, 8'h00,  0, 8'h3C, 1, 1, 0, 8'hFF);
      vecs[14] = mk(0, 0, 0, 8'h00,  0, 8'h3C, 1, 1, 0, 8'hFF);
      vecs[15] = mk(0, 0, 0, 8'h00,  0, 8'h3C, 0, 1, 0, 8'h3C);
      vecs[16] = mk(0, 0, 0, 8'h00,  1, 8'h3C, 0, 1, 1, 8'h3C);
      vecs[17] = mk(0, 0, 0, 8'h00,  1, 8'h3C, 0, 1, 0, 8'h3C);
      vecs[18] = mk(0, 1, 0, 8'h5A,  0, 8'h5A, 0, 1, 0, 8'h3C);
      vecs[19] = mk(0, 0, 0, 8'h00,  0, 8'h5A, 1, 1, 0, 8'h3C);
      vecs[20] = mk(1, 1, 0, 8'h77,  1, 8'h00, 0, 1, 0, 8'h00); // reset mid-pulse
      vecs[21] = mk(0, 0, 0, 8'h00,  1, 8'h00, 0, 1, 0, 8'h00);
      vecs[22] = mk(0, 0, 0, 8'h00,  1, 8'h00, 0, 1, 0, 8'h00);
      vecs[23] = mk(0, 0, 1, 8'h00,  0, 8'h00, 0, 0, 0, 8'h00);
      vecs[24] = mk(1, 0, 0, 8'h00,  1, 8'h00, 0, 1, 0, 8'h00); // reset mid-preset
      vecs[25] = mk(0, 0, 0, 8'h00,  1, 8'h00, 0, 1, 0, 8'h00);

      rst_a = 1'b1; wr_vld_a = 1'b0; pre_vld_a = 1'b0; wr_dat_a = 8'h00;
      rst_b = 1'b1; wr_vld_b = 1'b0; pre_vld_b = 1'b0; wr_dat_b = 8'h00;

      for (int i = 0; i < NV; i++) begin
         rst_a     = vecs[i].rst;
         wr_vld_a  = vecs[i].wr;
         pre_vld_a = vecs[i].pre;
         wr_dat_a  = vecs[i].dat;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d.ready", i), 32'(rdy_a),  32'(vecs[i].rdy));
         chk($sformatf("v%0d.d", i),     32'(d_a),    32'(vecs[i].d));
         chk($sformatf("v%0d.e", i),     32'(e_a),    32'(vecs[i].e));
         chk($sformatf("v%0d.setn", i),  32'(setn_a), 32'(vecs[i].setn));
         chk($sformatf("v%0d.done", i),  32'(done_a), 32'(vecs[i].done));
         chk($sformatf("v%0d.mirror", i),32'(mir_a),  32'(vecs[i].mir));
      end
      rst_a = 1'b0; wr_vld_a = 1'b0; pre_vld_a = 1'b0;

      // Back-to-back writes with valid held high
      n_acc = 0; viol = 0; n_done = 0; e_cycles = 0; last_dat = 8'h00;
      acc_cyc[0] = 0; acc_cyc[1] = 0;
      wr_vld_a = 1'b1; wr_dat_a = 8'h01;
      for (int cyc = 0; cyc < 30; cyc++) begin
         acc = rdy_a && wr_vld_a;
         @(posedge clk);
         #1;
         if (acc) begin
            acc_cyc[n_acc] = cyc;
            last_dat = wr_dat_a;
            n_acc++;
            if (n_acc == 1) wr_dat_a = 8'h02;
            if (n_acc == 2) wr_vld_a = 1'b0;
         end
         if (e_a && !setn_a) viol++;
         if (n_acc > 0 && d_a !== last_dat) viol++;
         if (e_a) e_cycles++;
         if (done_a) n_done++;
      end
      chk("b2b.accepts", 32'(n_acc), 32'd2);
      chk("b2b.spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
      chk("b2b.violations", 32'(viol), 32'd0);
      chk("b2b.e_cycles", 32'(e_cycles), 32'd4);
      chk("b2b.dones", 32'(n_done), 32'd2);
      chk("b2b.mirror", 32'(mir_a), 32'h02);

      // Second instance: SETUP=3, PULSE=1, HOLD=4
      @(posedge clk);
      #1;
      rst_b = 1'b0;
      @(posedge clk);
      #1;
      chk("p.idle_ready", 32'(rdy_b), 32'd1);
      chk("p.idle_e", 32'(e_b), 32'd0);
      wr_vld_b = 1'b1; wr_dat_b = 8'hFF;
      @(posedge clk);
      #1;
      wr_vld_b = 1'b0;
      chk("p.accept_ready", 32'(rdy_b), 32'd0);
      chk("p.accept_d", 32'(d_b), 32'hFF);
      rise_k = -1; done_k = -1; e_cnt = 0; done_cnt = 0; setn_lo = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         if (e_b) begin
            e_cnt++;
            if (rise_k < 0) rise_k = k;
         end
         if (done_b) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (!setn_b) setn_lo++;
      end
      chk("p.e_rise", 32'(rise_k), 32'd3);
      chk("p.e_cycles", 32'(e_cnt), 32'd1);
      chk("p.done_at", 32'(done_k), 32'd8);
      chk("p.done_cnt", 32'(done_cnt), 32'd1);
      chk("p.setn_low", 32'(setn_lo), 32'd0);
      chk("p.mirror", 32'(mir_b), 32'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
